lsu_mem_access: RTL and testbench

//  MEM-stage load/store initiator that drives the word-addressed, byte-enabled data memory.
//  - Stores: converts SW/SH/SB plus a byte address into the word address, byte enables and write data.
//  - Loads: returns LW/LH/LHU/LB/LBU results, extracted and sign- or zero-extended.
//  - Models WAIT_CYCLES of memory latency with a small FSM.
//  - Stalls the pipeline while an access is in flight.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_load_ext.sv | 39 +++
 rtl/lsu_mem_access.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_access.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the MEM-stage load/store unit:
//                mem_op encodings, op classification helpers, FSM state
//                type and the byte-enable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_OP_LW  = 3'b000;
    localparam logic [2:0] c_OP_LH  = 3'b001;
    localparam logic [2:0] c_OP_LHU = 3'b010;
    localparam logic [2:0] c_OP_LB  = 3'b011;
    localparam logic [2:0] c_OP_LBU = 3'b100;
    localparam logic [2:0] c_OP_SW  = 3'b101;
    localparam logic [2:0] c_OP_SH  = 3'b110;
    localparam logic [2:0] c_OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic is_store(input logic [2:0] op);
        return op inside {c_OP_SW, c_OP_SH, c_OP_SB};
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return op inside {c_OP_LW, c_OP_SW};
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return op inside {c_OP_LH, c_OP_LHU, c_OP_SH};
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return op inside {c_OP_LB, c_OP_LBU, c_OP_SB};
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return op inside {c_OP_LH, c_OP_LB};
    endfunction

    // Byte lanes touched by an access; computed identically for loads and stores.
    function automatic logic [3:0] lsu_be(input logic [2:0] op, input logic [1:0] addr_lo);
        if (is_byte(op)) begin
            return 4'b0001 << addr_lo;
        end else if (is_half(op)) begin
            return addr_lo[1] ? 4'b1100 : 4'b0011;
        end else begin
            return 4'b1111;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_ext
//  Description : Combinational load extractor. Selects the addressed byte or
//                halfword from a memory word and sign/zero extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] rdata32
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by width-dependent extension.
    always_comb begin
        w_byte  = 8'd0;
        w_half  = addr_lo[1] ? word[31:16] : word[15:0];
        rdata32 = word;
        case (addr_lo)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        if (is_byte(op)) begin
            rdata32 = is_signed(op) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        end else if (is_half(op)) begin
            rdata32 = is_signed(op) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_access
//  Description : MEM-stage load/store initiator for a word-addressed,
//                byte-enabled data memory with WAIT_CYCLES of latency.
//                Optional macro MISALIGN_TRAP_EN: misaligned accesses trap
//                (exc_adel/exc_ades) instead of being silently aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [2:0]    mem_op,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          exc_adel,
    output logic          exc_ades,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [3:0]  r_cnt;
    logic [1:0]  w_lo_eff;
    logic        w_trap;
    logic        w_accept;
    logic        w_commit;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    // Byte address bits above the memory's reach are intentionally ignored.
    assign w_unused_addr = ^addr[31:AW+2];

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_exc_l;
    logic r_exc_s;

    // Misaligned accesses trap; the address is passed through untouched.
    assign w_misalign = (is_word(mem_op) && (addr[1:0] != 2'b00)) ||
                        (is_half(mem_op) && addr[0]);
    assign w_trap     = w_misalign;
    assign w_lo_eff   = addr[1:0];

    // Trap flavour remembered at accept and presented with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc_l <= 1'b0;
            r_exc_s <= 1'b0;
        end else if (w_accept) begin
            r_exc_l <= w_trap && !is_store(mem_op);
            r_exc_s <= w_trap &&  is_store(mem_op);
        end
    end

    assign exc_adel = (r_state == DONE) && r_exc_l;
    assign exc_ades = (r_state == DONE) && r_exc_s;
`else
    // Misaligned low bits are forced to the natural alignment of the op.
    assign w_trap   = 1'b0;
    assign w_lo_eff = is_word(mem_op) ? 2'b00 :
                      is_half(mem_op) ? {addr[1], 1'b0} : addr[1:0];
    assign exc_adel = 1'b0;
    assign exc_ades = 1'b0;
`endif

    lsu_load_ext u_load_ext (
        .op      (r_op),
        .addr_lo (r_addr_lo),
        .word    (dm_dout),
        .rdata32 (w_ext)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-state outputs; dm_we is combinational so reset kills it at once.
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        done        = 1'b0;
        dm_we       = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                stall = req;
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_trap ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    dm_we       = is_store(r_op);
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch and memory-side drive, held stable for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= c_OP_LW;
            r_addr_lo <= 2'b00;
            dm_addr   <= '0;
            dm_be     <= 4'b0000;
            dm_din    <= 32'd0;
        end else if (w_accept) begin
            r_op      <= mem_op;
            r_addr_lo <= w_lo_eff;
            dm_addr   <= addr[AW+1:2];
            dm_be     <= lsu_be(mem_op, w_lo_eff);
            dm_din    <= wdata;
        end
    end

    // Latency counter: loaded on accept, counts down through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT;
        end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Load result captured in the final ACCESS cycle and held until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (w_commit && !is_store(r_op)) begin
            rdata <= w_ext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lsu_mem_access
//  Description : Self-checking bench for lsu_mem_access with a byte-level
//                reference model of memory and load/store semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_access;

    localparam int WAIT = 1;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [2:0]    mem_op = 3'd0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   wdata = 32'd0;
    logic          stall, done, exc_adel, exc_ades, dm_we;
    logic [31:0]   rdata, dm_din, dm_dout;
    logic [AW-1:0] dm_addr;
    logic [3:0]    dm_be;

    // second instance, zero wait states, for the back-to-back cadence check
    logic          req0 = 1'b0;
    logic          stall0, done0, exc_adel0, exc_ades0, dm_we0;
    logic [31:0]   rdata0, dm_din0;
    logic [31:0]   dm_dout0 = 32'd0;
    logic [AW-1:0] dm_addr0;
    logic [3:0]    dm_be0;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_rdata = 32'd0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [7:0]    ref_bytes [0:4095];

    always #5 clk = ~clk;

    lsu_mem_access #(.WAIT_CYCLES(WAIT), .AW(AW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    lsu_mem_access #(.WAIT_CYCLES(0), .AW(AW)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .mem_op(3'b000), .addr(32'd0), .wdata(32'd0),
        .stall(stall0), .done(done0), .rdata(rdata0), .exc_adel(exc_adel0), .exc_ades(exc_ades0),
        .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_be(dm_be0), .dm_din(dm_din0), .dm_dout(dm_dout0)
    );

    // Memory environment: combinational read, byte-lane write picking the low byte/half.
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_be)
                4'b1111: mem[dm_addr]        <= dm_din;
                4'b0011: mem[dm_addr][15:0]  <= dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] <= dm_din[15:0];
                4'b0001: mem[dm_addr][7:0]   <= dm_din[7:0];
                4'b0010: mem[dm_addr][15:8]  <= dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] <= dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] <= dm_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic bit op_signed(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd3);
    endfunction

    function automatic bit misaligned(input logic [2:0] op, input logic [31:0] a);
        return (a % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [2:0] op, input logic [31:0] a);
        return a - (a % op_size(op));
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        int sz;
        sz = op_size(op);
        return 4'(((1 << sz) - 1) << (eff_addr(op, a) % 4));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] ea, v;
        int sz;
        sz = op_size(op);
        ea = eff_addr(op, a);
        v  = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(ref_bytes[ea + k]) << (8 * k));
        if (op_signed(op) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ea;
        ea = eff_addr(op, a);
        for (int k = 0; k < op_size(op); k++) ref_bytes[ea + k] = 8'(wd >> (8 * k));
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx] = val;
        for (int k = 0; k < 4; k++) ref_bytes[4*idx + k] = 8'(val >> (8 * k));
    endtask

    // One complete access; checks timing, memory drive, write pulse, exceptions, result.
    task automatic run_access(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input string tag);
        int lat, we_cnt, we_cyc, exp_lat;
        bit trap;
        logic [31:0] ea;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = misaligned(op, a);
`endif
        exp_lat = trap ? 1 : WAIT + 2;
        ea      = eff_addr(op, a);
        @(negedge clk);
        req = 1'b1; mem_op = op; addr = a; wdata = wd;
        #1 chk($sformatf("%s.stall_c0", tag), 32'(stall), 32'd1);
        lat = 0; we_cnt = 0; we_cyc = -1;
        do begin
            @(negedge clk);
            lat++;
            if (dm_we) begin we_cnt++; we_cyc = lat; end
            if (!done && lat <= 40) begin
                chk($sformatf("%s.stall_acc", tag), 32'(stall), 32'd1);
                chk($sformatf("%s.dm_addr", tag), 32'(dm_addr), 32'(ea[AW+1:2]));
                chk($sformatf("%s.dm_be", tag), 32'(dm_be), 32'(exp_be(op, a)));
                chk($sformatf("%s.dm_din", tag), dm_din, wd);
            end
        end while (!done && lat <= 40);
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s.stall_done", tag), 32'(stall), 32'd0);
        chk($sformatf("%s.exc_adel", tag), 32'(exc_adel), 32'(trap && !op_store(op)));
        chk($sformatf("%s.exc_ades", tag), 32'(exc_ades), 32'(trap && op_store(op)));
        chk($sformatf("%s.we_count", tag), 32'(we_cnt), 32'(op_store(op) && !trap));
        if (op_store(op) && !trap)
            chk($sformatf("%s.we_cycle", tag), 32'(we_cyc), 32'(WAIT + 1));
        if (!trap) begin
            if (op_store(op)) ref_store(op, a, wd);
            else              exp_rdata = ref_load(op, a);
        end
        chk($sformatf("%s.rdata", tag), rdata, exp_rdata);
        req = 1'b0;
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) set_word(i, $urandom);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.dm_addr", 32'(dm_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.dm_we", 32'(dm_we), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.dm_be", 32'(dm_be), 32'd0);
        chk("reset.dm_din", dm_din, 32'd0);
        chk("reset.exc", 32'({exc_adel, exc_ades}), 32'd0);

        // SW word store
        run_access(3'd5, 32'h10, 32'hDEADBEEF, "sw10");
        chk("sw10.mem", mem[4], 32'hDEADBEEF);

        // SB into upper lane, then read back the word
        set_word(4, 32'h11223344);
        run_access(3'd7, 32'h13, 32'h000000A5, "sb13");
        run_access(3'd0, 32'h10, 32'h0, "lw10");
        chk("lw10.literal", rdata, 32'hA5223344);

        // Extraction and extension
        set_word(8, 32'h80FF7F01);
        run_access(3'd3, 32'h20, 32'h0, "lb20");
        chk("lb20.literal", rdata, 32'h00000001);
        run_access(3'd3, 32'h22, 32'h0, "lb22");
        chk("lb22.literal", rdata, 32'hFFFFFFFF);
        run_access(3'd4, 32'h23, 32'h0, "lbu23");
        chk("lbu23.literal", rdata, 32'h00000080);
        run_access(3'd1, 32'h22, 32'h0, "lh22");
        chk("lh22.literal", rdata, 32'hFFFF80FF);
        run_access(3'd2, 32'h22, 32'h0, "lhu22");
        chk("lhu22.literal", rdata, 32'h000080FF);

        // Misaligned word load
        run_access(3'd0, 32'h22, 32'h0, "lw22");
`ifdef MISALIGN_TRAP_EN
        chk("lw22.literal", rdata, 32'h000080FF);
`else
        chk("lw22.literal", rdata, 32'h80FF7F01);
`endif

        // Randomised traffic over a small window so loads see earlier stores
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  r_op;
            logic [31:0] r_a;
            r_op = 3'($urandom_range(0, 7));
            r_a  = 32'($urandom_range(0, 255));
            run_access(r_op, r_a, $urandom, $sformatf("rnd%0d", n));
        end

        // Reset in the write cycle of a store
        @(negedge clk);
        req = 1'b1; mem_op = 3'd5; addr = 32'h40; wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.we_before", 32'(dm_we), 32'd1);
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid.dm_we", 32'(dm_we), 32'd0);
        chk("rstmid.stall", 32'(stall), 32'd0);
        chk("rstmid.done", 32'(done), 32'd0);
        chk("rstmid.rdata", rdata, 32'd0);
        chk("rstmid.dm_addr", 32'(dm_addr), 32'd0);
        chk("rstmid.dm_be", 32'(dm_be), 32'd0);
        chk("rstmid.dm_din", dm_din, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid.no_done", 32'(done), 32'd0);
        end
        run_access(3'd0, 32'h40, 32'h0, "rstmid.lw");

        // Zero-wait instance with req held: accept, access, done, repeat
        @(negedge clk);
        req0 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("b2b.done%0d", c), 32'(done0), 32'((c % 3) == 2));
            chk($sformatf("b2b.stall%0d", c), 32'(stall0), 32'((c % 3) != 2));
        end
        req0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
